// File: rtl/adder_self_test_if.sv
// Operand/result bus between the self-test controller and a 2-bit adder under test.
// The controller drives a/b/c0 and samples {c2,s} back.
interface adder_self_test_if;
  logic [1:0] a;
  logic [1:0] b;
  logic       c0;
  logic [1:0] s;
  logic       c2;

  modport master (output a, b, c0, input s, c2);
  modport slave  (input a, b, c0, output s, c2);
endinterface

// File: rtl/adder_self_test.sv
// Exhaustive 32-vector self-test for a 2-bit adder with carry-in and carry-out.
// Define STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module adder_self_test #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  adder_self_test_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [5:0]         err_count,
  output logic [4:0]         fail_idx,
  output logic               fail_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] LAST_IDX    = 5'd31;
  localparam logic [5:0] ERR_MAX     = 6'd32;

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [5:0] err_q, err_d;
  logic [4:0] fidx_q, fidx_d;
  logic       fvalid_q, fvalid_d;

  logic [2:0] sum_exp;
  logic [2:0] sum_obs;
  logic       mismatch;
  logic       stop_now;
  logic [5:0] err_next;

  // The driven vector is the index register itself, so a/b/c0 are registered
  // and hold their value through SETTLE, CHECK and DONE.
  assign bus.c0 = idx_q[4];
  assign bus.a  = idx_q[3:2];
  assign bus.b  = idx_q[1:0];

  assign sum_exp  = {1'b0, idx_q[3:2]} + {1'b0, idx_q[1:0]} + {2'b00, idx_q[4]};
  assign sum_obs  = {bus.c2, bus.s};
  assign mismatch = (sum_obs != sum_exp);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fvalid_d = fvalid_q;
    err_next = err_q;
    stop_now = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SETTLE;
          idx_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          fidx_d   = '0;
          fvalid_d = 1'b0;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_next = err_q + 6'd1;
          end
          if (!fvalid_q) begin
            fidx_d   = idx_q;
            fvalid_d = 1'b1;
          end
`ifdef STOP_ON_FAIL_EN
          stop_now = 1'b1;
`else
          stop_now = 1'b0;
`endif
        end
        err_d = err_next;

        if ((idx_q == LAST_IDX) || stop_now) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = SETTLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fidx_q   <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_idx   = fidx_q;
  assign fail_valid = fvalid_q;

endmodule

// File: tb/tb_adder_self_test.sv
// Bench for adder_self_test: a fault-injectable adder model feeds the DUT and a
// vector-level reference predicts latency, error count and first failing index.
module tb_adder_self_test;

  localparam int SETTLE     = 2;
  localparam int PER_VEC    = SETTLE + 1;
  localparam int RUN_CYCLES = 32 * PER_VEC;

  // Adder behaviours: 0 good, 1 c2 stuck at 0, 2 s[0] stuck at 1, 3 random per-vector corruption
  localparam int M_GOOD = 0;
  localparam int M_C2_0 = 1;
  localparam int M_S0_1 = 2;
  localparam int M_RAND = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_count;
  logic [4:0] fail_idx;
  logic       fail_valid;

  int          fault_mode;
  logic [31:0] fault_map;
  logic [2:0]  flip_val;
  logic [2:0]  adder_out;

  int n_checks = 0;
  int n_errors = 0;

  adder_self_test_if bus ();

  adder_self_test #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_idx   (fail_idx),
    .fail_valid (fail_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] adder_model(int mode, logic [4:0] v, logic [31:0] fmap, logic [2:0] flip);
    int sum;
    sum = int'(v[3:2]) + int'(v[1:0]) + int'(v[4]);
    case (mode)
      M_C2_0:  return 3'(sum) & 3'b011;
      M_S0_1:  return 3'(sum) | 3'b001;
      M_RAND:  return fmap[v] ? (3'(sum) ^ flip) : 3'(sum);
      default: return 3'(sum);
    endcase
  endfunction

  always_comb adder_out = adder_model(fault_mode, {bus.c0, bus.a, bus.b}, fault_map, flip_val);
  assign bus.s  = adder_out[1:0];
  assign bus.c2 = adder_out[2];

  task automatic check(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cur_vec();
    return int'({bus.c0, bus.a, bus.b});
  endfunction

  task automatic expect_reset_state(string tag);
    check({tag, "_busy"},   int'(busy), 0);
    check({tag, "_done"},   int'(done), 0);
    check({tag, "_pass"},   int'(pass), 0);
    check({tag, "_errs"},   int'(err_count), 0);
    check({tag, "_fidx"},   int'(fail_idx), 0);
    check({tag, "_fvalid"}, int'(fail_valid), 0);
    check({tag, "_vec"},    cur_vec(), 0);
  endtask

  // One complete run; repulse_at > 0 re-pulses start after that many cycles.
  task automatic run(string tag, int mode, int repulse_at);
    int errs = 0;
    int first = -1;
    int exp_cycles, exp_err, exp_last;
    int cycles = 0;
    int seq_err = 0;
    logic [4:0] vv;

    for (int v = 0; v < 32; v++) begin
      vv = 5'(v);
      if (adder_model(mode, vv, fault_map, flip_val) != adder_model(M_GOOD, vv, fault_map, flip_val)) begin
        errs++;
        if (first < 0) first = v;
      end
    end
`ifdef STOP_ON_FAIL_EN
    exp_cycles = (errs > 0) ? PER_VEC * (first + 1) : RUN_CYCLES;
    exp_err    = (errs > 0) ? 1 : 0;
    exp_last   = (errs > 0) ? first : 31;
`else
    exp_cycles = RUN_CYCLES;
    exp_err    = errs;
    exp_last   = 31;
`endif

    fault_mode = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_busy"},   int'(busy), 1);
    check({tag, "_start_done"},   int'(done), 0);
    check({tag, "_start_errs"},   int'(err_count), 0);
    check({tag, "_start_fvalid"}, int'(fail_valid), 0);
    check({tag, "_start_vec"},    cur_vec(), 0);

    while (!done && cycles < RUN_CYCLES + 50) begin
      tick();
      cycles++;
      start = (cycles == repulse_at);
      if (busy && cur_vec() != cycles / PER_VEC) seq_err++;
      if (!busy && !done) seq_err++;
    end
    start = 1'b0;

    check({tag, "_latency"},  cycles, exp_cycles);
    check({tag, "_sequence"}, seq_err, 0);
    check({tag, "_busy"},     int'(busy), 0);
    check({tag, "_pass"},     int'(pass), (errs == 0) ? 1 : 0);
    check({tag, "_errs"},     int'(err_count), exp_err);
    check({tag, "_fvalid"},   int'(fail_valid), (errs > 0) ? 1 : 0);
    check({tag, "_fidx"},     int'(fail_idx), (errs > 0) ? first : 0);
    check({tag, "_lastvec"},  cur_vec(), exp_last);
    tick();
    check({tag, "_done_held"}, int'(done), 1);
    check({tag, "_vec_held"},  cur_vec(), exp_last);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    fault_mode = M_GOOD;
    fault_map  = '0;
    flip_val   = 3'd1;
    repeat (3) tick();
    expect_reset_state("por");
    reset = 1'b0;
    tick();

    run("good", M_GOOD, -1);
    run("c2_stuck0", M_C2_0, -1);
    run("s0_stuck1", M_S0_1, -1);

    fault_map = 32'h8000_0000;
    flip_val  = 3'd4;
    run("last_only", M_RAND, -1);

    for (int i = 0; i < 4; i++) begin
      fault_map = $urandom;
      if (i == 3) fault_map = fault_map & $urandom & $urandom;
      flip_val  = 3'($urandom_range(1, 7));
      run("random", M_RAND, -1);
    end

    run("repulse", M_GOOD, 10);

    fault_mode = M_GOOD;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    reset = 1'b1;
    tick();
    expect_reset_state("midrun_reset");
    reset = 1'b0;
    tick();
    tick();
    run("after_reset", M_GOOD, -1);

    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_reset_state("reset_over_start");
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
